// File: rtl/quad_pkg.sv
// Shared types and Gray-code helpers for the quadrature step decoder.
package quad_pkg;

   // Filtered encoder state, packed as {a, b}.
   typedef logic [1:0] qstate_t;

   // Gray-code states in the order visited by forward rotation.
   localparam qstate_t S00 = 2'b00;
   localparam qstate_t S01 = 2'b01;
   localparam qstate_t S11 = 2'b11;
   localparam qstate_t S10 = 2'b10;

   // Outcome of comparing two consecutive filtered states.
   typedef enum logic [1:0] {
      DIR_NONE    = 2'd0,
      DIR_UP      = 2'd1,
      DIR_DOWN    = 2'd2,
      DIR_ILLEGAL = 2'd3
   } qdir_t;

   // Classify a transition: +1 along 00->01->11->10->00, -1 against it,
   // no action if unchanged, illegal if both bits flipped at once.
   function automatic qdir_t qdir(input qstate_t prev, input qstate_t cur);
      qdir_t result;
      if (prev == cur) begin
         result = DIR_NONE;
      end else begin
         case ({prev, cur})
            {S00, S01}, {S01, S11}, {S11, S10}, {S10, S00}: result = DIR_UP;
            {S00, S10}, {S10, S11}, {S11, S01}, {S01, S00}: result = DIR_DOWN;
            default:                                        result = DIR_ILLEGAL;
         endcase
      end
      return result;
   endfunction

endpackage

// File: rtl/quad_step_decoder_input_filter.sv
// One encoder channel: two-flop synchroniser followed by a debounce filter
// that accepts a new level only after it has been stable for DEBOUNCE cycles.
module input_filter #(
   parameter int DEBOUNCE = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level
);

   localparam int CNT_W = $clog2(DEBOUNCE + 1);
   localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE);

   logic             sync_1;
   logic             sync_2;
   logic [CNT_W-1:0] run_cnt;

   // Bring the asynchronous pin into the clk domain.
   // NOTE: the reset term sits in the sensitivity list, so rst_n clears these
   // flops at once without waiting for a clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make the chain shift by one stage per
         // edge; blocking ones would collapse both flops into a single stage.
         sync_1 <= raw;
         sync_2 <= sync_1;
      end
   end

   // Count consecutive cycles of disagreement; any agreement restarts the run.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_cnt <= '0;
         level   <= 1'b0;
      end else if (sync_2 == level) begin
         run_cnt <= '0;
      end else if (run_cnt == CNT_DONE) begin
         level   <= sync_2;
         run_cnt <= '0;
      end else begin
         run_cnt <= run_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature front end: filters raw A/B pins, decodes Gray-code transitions
// into an edge accumulator, and emits one-cycle step pulses with direction
// plus a wrapping position count. Illegal double-bit jumps set a sticky err.
module quad_step_decoder
   import quad_pkg::*;
#(
   parameter int WIDTH          = 8,
   parameter int DEBOUNCE       = 4,
   parameter int EDGES_PER_STEP = 4   // 1, 2 or 4 edges per detent
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enc_a,
   input  logic             enc_b,
   input  logic             err_clr,
   output logic             step,
   output logic             up,
   output logic [WIDTH-1:0] count,
   output logic             err
);

   // One sign bit beyond what is needed to hold +/-EDGES_PER_STEP.
   localparam int ACC_W = $clog2(EDGES_PER_STEP + 1) + 1;
   typedef logic signed [ACC_W-1:0] acc_t;
   localparam acc_t ACC_TOP = acc_t'(EDGES_PER_STEP);
   localparam acc_t ACC_BOT = acc_t'(-EDGES_PER_STEP);

   logic    filt_a;
   logic    filt_b;
   qstate_t cur_state;
   qstate_t prev_state;
   qdir_t   dir;
   acc_t    acc;
   acc_t    acc_next;

   input_filter #(.DEBOUNCE(DEBOUNCE)) u_filter_a (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (enc_a),
      .level (filt_a)
   );

   input_filter #(.DEBOUNCE(DEBOUNCE)) u_filter_b (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (enc_b),
      .level (filt_b)
   );

   assign cur_state = {filt_a, filt_b};

   // Classify the latest filtered transition and form the candidate accumulator.
   always_comb begin
      // NOTE: default first so every path assigns acc_next and no latch appears.
      acc_next = acc;
      dir      = qdir(prev_state, cur_state);
      case (dir)
         DIR_UP:   acc_next = acc + acc_t'(1);
         DIR_DOWN: acc_next = acc - acc_t'(1);
         default:  acc_next = acc;
      endcase
   end

   // Register decode result: emit a step at a full detent, track position.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_state <= S00;
         acc        <= '0;
         step       <= 1'b0;
         up         <= 1'b0;
         count      <= '0;
      end else begin
         prev_state <= cur_state;
         step       <= 1'b0;
         if (acc_next == ACC_TOP) begin
            step  <= 1'b1;
            up    <= 1'b1;
            count <= count + WIDTH'(1);
            acc   <= '0;
         end else if (acc_next == ACC_BOT) begin
            step  <= 1'b1;
            up    <= 1'b0;
            count <= count - WIDTH'(1);
            acc   <= '0;
         end else begin
            acc   <= acc_next;
         end
      end
   end

   // Sticky illegal-transition flag; a new violation outranks a clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err <= 1'b0;
      end else if (dir == DIR_ILLEGAL) begin
         err <= 1'b1;
      end else if (err_clr) begin
         err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed bench for quad_step_decoder: a behavioural model predicts each
// step as the stimulus is driven; a monitor pops and compares on every pulse.
module tb_quad_step_decoder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enc_a;
   logic       enc_b;
   logic       err_clr;
   logic       step;
   logic       up;
   logic [7:0] count;
   logic       err;

   typedef struct {
      logic       up;
      logic [7:0] count;
   } step_exp_t;

   step_exp_t  exp_q[$];
   int         vectors     = 0;
   int         miscompares = 0;

   // Behavioural model of filtered state, accumulator and position.
   logic [1:0] m_state;
   int         m_acc;
   logic [7:0] m_count;
   logic       prev_step = 1'b0;

   quad_step_decoder #(
      .WIDTH          (8),
      .DEBOUNCE       (4),
      .EDGES_PER_STEP (4)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .enc_a   (enc_a),
      .enc_b   (enc_b),
      .err_clr (err_clr),
      .step    (step),
      .up      (up),
      .count   (count),
      .err     (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Position of a state along the forward Gray sequence.
   function automatic int gpos(input logic [1:0] s);
      case (s)
         2'b00:   return 0;
         2'b01:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   // Drive new pin levels and advance the model; push a step when due.
   task automatic drive(input logic a, input logic b);
      logic [1:0] nxt;
      int         d;
      enc_a = a;
      enc_b = b;
      nxt   = {a, b};
      if (nxt != m_state) begin
         d = (gpos(nxt) - gpos(m_state) + 4) % 4;
         if (d == 1)      m_acc++;
         else if (d == 3) m_acc--;
         m_state = nxt;
         if (m_acc == 4) begin
            m_acc   = 0;
            m_count = m_count + 8'd1;
            exp_q.push_back('{up: 1'b1, count: m_count});
         end else if (m_acc == -4) begin
            m_acc   = 0;
            m_count = m_count - 8'd1;
            exp_q.push_back('{up: 1'b0, count: m_count});
         end
      end
   endtask

   task automatic hold(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic visit(input logic a, input logic b);
      drive(a, b);
      hold(10);
   endtask

   task automatic up_cycle();
      visit(1'b0, 1'b1);
      visit(1'b1, 1'b1);
      visit(1'b1, 1'b0);
      visit(1'b0, 1'b0);
   endtask

   task automatic down_cycle();
      visit(1'b1, 1'b0);
      visit(1'b1, 1'b1);
      visit(1'b0, 1'b1);
      visit(1'b0, 1'b0);
   endtask

   // Every predicted step must have been seen and the position must agree.
   task automatic settle(input string tag);
      check({tag, "_pending_steps"}, 32'(exp_q.size()), 32'd0);
      check({tag, "_count"}, 32'(count), 32'(m_count));
   endtask

   // Scoreboard: each pulse consumes one prediction, pulses never repeat back to back.
   always @(negedge clk) begin
      step_exp_t e;
      if (step === 1'b1) begin
         check("step_single_cycle", 32'(prev_step), 32'd0);
         check("step_expected", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("step_up", 32'(up), 32'(e.up));
            check("step_count", 32'(count), 32'(e.count));
         end
      end
      prev_step = step;
   end

   initial begin
      rst_n   = 1'b0;
      enc_a   = 1'b0;
      enc_b   = 1'b0;
      err_clr = 1'b0;
      m_state = 2'b00;
      m_acc   = 0;
      m_count = 8'd0;
      hold(3);
      rst_n = 1'b1;
      hold(2);

      // Reset state.
      check("reset_step", 32'(step), 32'd0);
      check("reset_up", 32'(up), 32'd0);
      check("reset_count", 32'(count), 32'd0);
      check("reset_err", 32'(err), 32'd0);

      // 1: one full up cycle, with exact step latency on the final 00.
      visit(1'b0, 1'b1);
      visit(1'b1, 1'b1);
      visit(1'b1, 1'b0);
      drive(1'b0, 1'b0);
      hold(7);
      check("t1_no_early_step", 32'(step), 32'd0);
      hold(1);
      check("t1_step_latency", 32'(step), 32'd1);
      check("t1_up", 32'(up), 32'd1);
      hold(2);
      settle("t1");
      check("t1_count_one", 32'(count), 32'd1);
      check("t1_err", 32'(err), 32'd0);
      check("t1_up_held", 32'(up), 32'd1);

      // 2: four reverse cycles, wrapping through zero.
      for (int i = 0; i < 4; i++) down_cycle();
      settle("t2");
      check("t2_count_253", 32'(count), 32'd253);
      check("t2_up_low", 32'(up), 32'd0);

      // 3: glitch on A shorter than the debounce window.
      enc_a = 1'b1;
      hold(3);
      enc_a = 1'b0;
      hold(12);
      settle("t3");
      check("t3_err", 32'(err), 32'd0);

      // 4: partial detent reversed, then a full up cycle.
      visit(1'b0, 1'b1);
      visit(1'b1, 1'b1);
      visit(1'b0, 1'b1);
      visit(1'b0, 1'b0);
      settle("t4_reversal");
      up_cycle();
      settle("t4");
      check("t4_count_254", 32'(count), 32'd254);

      // 5: illegal jump, clear, then illegal jump coinciding with clear.
      visit(1'b1, 1'b1);
      check("t5_err_set", 32'(err), 32'd1);
      settle("t5_illegal");
      err_clr = 1'b1;
      hold(1);
      err_clr = 1'b0;
      check("t5_err_cleared", 32'(err), 32'd0);
      drive(1'b0, 1'b0);
      hold(7);
      check("t5_err_before_clash", 32'(err), 32'd0);
      err_clr = 1'b1;
      hold(1);
      err_clr = 1'b0;
      check("t5_set_wins", 32'(err), 32'd1);
      hold(5);
      err_clr = 1'b1;
      hold(1);
      err_clr = 1'b0;
      check("t5_err_final_clear", 32'(err), 32'd0);
      settle("t5");

      // 6: walk up through the 255->0 wrap to 5, stop mid-detent, reset.
      for (int i = 0; i < 7; i++) up_cycle();
      settle("t6_walk");
      check("t6_count_5", 32'(count), 32'd5);
      visit(1'b0, 1'b1);
      visit(1'b1, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_async_count", 32'(count), 32'd0);
      check("t6_async_step", 32'(step), 32'd0);
      check("t6_async_up", 32'(up), 32'd0);
      enc_a   = 1'b0;
      enc_b   = 1'b0;
      m_state = 2'b00;
      m_acc   = 0;
      m_count = 8'd0;
      exp_q.delete();
      hold(3);
      rst_n = 1'b1;
      hold(2);
      up_cycle();
      settle("t6");
      check("t6_count_one", 32'(count), 32'd1);
      check("t6_err", 32'(err), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
